// File: rtl/wb2axi_buffer_pkg.sv
// Shared types and sizing helpers for the wb2axi elastic buffer.
package wb2axi_buffer_pkg;

    typedef enum logic {
        FT_OFF = 1'b0,
        FT_ON  = 1'b1
    } ft_mode_e;

    // Pointer width; a single-entry buffer still carries a 1-bit (constant 0) pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter width, able to represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb2axi_buffer_ptr.sv
// Wrap-around index counter for the buffer read/write pointers.
module wb2axi_buffer_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

    // Advance on inc_i, wrapping explicitly at DEPTH-1; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= (ptr_o == LAST) ? '0 : ptr_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb2axi_elastic_buffer.sv
// Parametrised elastic buffer for the wb2axi request/response paths with
// optional fall-through, synchronous flush and occupancy flags.
module wb2axi_elastic_buffer
    import wb2axi_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned FALL_THROUGH = 0,
    parameter int unsigned AF_THRESH    = BUFFER_DEPTH - 1,
    parameter int unsigned AE_THRESH    = 1,
    parameter int unsigned CNT_WIDTH    = cnt_width(BUFFER_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam int unsigned PTR_W   = ptr_width(BUFFER_DEPTH);
    localparam ft_mode_e    FT_MODE = (FALL_THROUGH != 0) ? FT_ON : FT_OFF;
    localparam logic        FT_EN   = (FT_MODE == FT_ON);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    // Handshake and status decode; ready_o depends only on count and flush.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_WIDTH'(BUFFER_DEPTH));
    assign ready_o = ~full & ~flush_i;
    assign valid_o = (FT_EN && empty) ? valid_i : ~empty;
    assign data_o  = (FT_EN && empty) ? data_i  : mem_q[rd_ptr];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i & ~flush_i;
    // A beat consumed while empty in fall-through mode never touches storage.
    assign bypass  = FT_EN & empty & push & ready_i;
    assign wr_en   = push & ~bypass;
    assign rd_en   = pop & ~empty;

    assign count_o        = count_q;
    assign almost_full_o  = (32'(count_q) >= AF_THRESH);
    assign almost_empty_o = (32'(count_q) <= AE_THRESH);

    // Next occupancy: flush wins, otherwise stored pushes minus stored pops.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage array; contents survive a flush and are only cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

    wb2axi_buffer_ptr #(
        .DEPTH (BUFFER_DEPTH),
        .WIDTH (PTR_W)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (wr_en),
        .ptr_o  (wr_ptr)
    );

    wb2axi_buffer_ptr #(
        .DEPTH (BUFFER_DEPTH),
        .WIDTH (PTR_W)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (rd_en),
        .ptr_o  (rd_ptr)
    );

    // Occupancy must stay within 0..BUFFER_DEPTH.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(full && wr_en && !rd_en) && (32'(count_q) <= BUFFER_DEPTH));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(empty && rd_en && !wr_en));

endmodule

// File: tb/tb_wb2axi_elastic_buffer.sv
// Bench for wb2axi_elastic_buffer: four configurations checked against a
// list-based reference model, plus directed scenario tasks.
module tb_wb2axi_elastic_buffer;

    localparam int DEP [4] = '{3, 4, 4, 1};
    localparam int FTM [4] = '{0, 0, 1, 0};

    logic clk;
    logic rst_n;
    logic [3:0]      vld_i, rdy_i, fl_i;
    logic [3:0][7:0] dat_i;
    logic [3:0]      vld_o, rdy_o, af_o, ae_o;
    logic [3:0][7:0] dat_o;
    logic [1:0] c0;
    logic [2:0] c1;
    logic [2:0] c2;
    logic [0:0] c3;

    int tests = 0;
    int fails = 0;

    // Reference model: per-instance ordered list of stored beats.
    int         mn [4];
    logic [7:0] mq [4][4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb2axi_elastic_buffer #(.DATA_WIDTH(8), .BUFFER_DEPTH(3), .FALL_THROUGH(0)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_i[0]), .valid_i(vld_i[0]), .data_i(dat_i[0]),
        .ready_o(rdy_o[0]), .valid_o(vld_o[0]), .data_o(dat_o[0]), .ready_i(rdy_i[0]),
        .count_o(c0), .almost_full_o(af_o[0]), .almost_empty_o(ae_o[0]));

    wb2axi_elastic_buffer #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FALL_THROUGH(0)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_i[1]), .valid_i(vld_i[1]), .data_i(dat_i[1]),
        .ready_o(rdy_o[1]), .valid_o(vld_o[1]), .data_o(dat_o[1]), .ready_i(rdy_i[1]),
        .count_o(c1), .almost_full_o(af_o[1]), .almost_empty_o(ae_o[1]));

    wb2axi_elastic_buffer #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FALL_THROUGH(1)) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_i[2]), .valid_i(vld_i[2]), .data_i(dat_i[2]),
        .ready_o(rdy_o[2]), .valid_o(vld_o[2]), .data_o(dat_o[2]), .ready_i(rdy_i[2]),
        .count_o(c2), .almost_full_o(af_o[2]), .almost_empty_o(ae_o[2]));

    wb2axi_elastic_buffer #(.DATA_WIDTH(8), .BUFFER_DEPTH(1), .FALL_THROUGH(0)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl_i[3]), .valid_i(vld_i[3]), .data_i(dat_i[3]),
        .ready_o(rdy_o[3]), .valid_o(vld_o[3]), .data_o(dat_o[3]), .ready_i(rdy_i[3]),
        .count_o(c3), .almost_full_o(af_o[3]), .almost_empty_o(ae_o[3]));

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(c0);
            1:       return int'(c1);
            2:       return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mn[i] = 0;
    endtask

    // One clock: compare every instance with the model, advance the model, clock.
    task automatic cycle();
        int         d;
        bit         ft, e_rdy, e_vld, push, pop;
        logic [7:0] e_dat;
        #1;
        for (int i = 0; i < 4; i++) begin
            d     = DEP[i];
            ft    = (FTM[i] == 1);
            e_rdy = (mn[i] != d) && !fl_i[i];
            e_vld = (ft && mn[i] == 0) ? vld_i[i] : (mn[i] != 0);
            e_dat = (ft && mn[i] == 0) ? dat_i[i] : mq[i][0];
            tests++;
            if (rdy_o[i] !== e_rdy) begin
                fails++; $display("FAIL ready_o inst%0d t=%0t got %b exp %b", i, $time, rdy_o[i], e_rdy);
            end
            tests++;
            if (vld_o[i] !== e_vld) begin
                fails++; $display("FAIL valid_o inst%0d t=%0t got %b exp %b", i, $time, vld_o[i], e_vld);
            end
            if (e_vld) begin
                tests++;
                if (dat_o[i] !== e_dat) begin
                    fails++; $display("FAIL data_o inst%0d t=%0t got %h exp %h", i, $time, dat_o[i], e_dat);
                end
            end
            tests++;
            if (get_cnt(i) != mn[i]) begin
                fails++; $display("FAIL count_o inst%0d t=%0t got %0d exp %0d", i, $time, get_cnt(i), mn[i]);
            end
            tests++;
            if (af_o[i] !== (mn[i] >= d - 1) || ae_o[i] !== (mn[i] <= 1)) begin
                fails++; $display("FAIL flags inst%0d t=%0t got af=%b ae=%b for count %0d", i, $time, af_o[i], ae_o[i], mn[i]);
            end
            if (fl_i[i]) begin
                mn[i] = 0;
            end else begin
                push = vld_i[i] && e_rdy;
                pop  = e_vld && rdy_i[i];
                if (!(ft && mn[i] == 0 && push && rdy_i[i])) begin
                    if (pop) begin
                        for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
                        mn[i]--;
                    end
                    if (push) begin
                        mq[i][mn[i]] = dat_i[i];
                        mn[i]++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        vld_i = '0; rdy_i = '0; fl_i = '0; dat_i = '0;
    endtask

    task automatic flush_all();
        idle_all();
        fl_i = 4'hF;
        cycle();
        fl_i = '0;
    endtask

    task automatic test_reset();
        dat_i[2] = 8'h3C;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (vld_o[i] !== 1'b0 || rdy_o[i] !== 1'b1 || get_cnt(i) != 0 || ae_o[i] !== 1'b1
                || af_o[i] !== (DEP[i] == 1)) begin
                fails++;
                $display("FAIL reset_state inst%0d got vld=%b rdy=%b cnt=%0d af=%b ae=%b", i, vld_o[i], rdy_o[i], get_cnt(i), af_o[i], ae_o[i]);
            end
        end
        tests++;
        if (dat_o[0] !== 8'h00 || dat_o[2] !== 8'h3C) begin
            fails++; $display("FAIL reset_data got d3=%h ft=%h exp 00 3c", dat_o[0], dat_o[2]);
        end
        dat_i[2] = 8'h00;
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 3; k++) begin
            vld_i[0] = 1'b1; dat_i[0] = 8'hA1 + 8'(k); rdy_i[0] = 1'b0;
            cycle();
        end
        vld_i[0] = 1'b0;
        #1;
        tests++;
        if (rdy_o[0] !== 1'b0 || c0 !== 2'd3 || af_o[0] !== 1'b1) begin
            fails++; $display("FAIL fill_full got rdy=%b cnt=%0d af=%b exp 0 3 1", rdy_o[0], c0, af_o[0]);
        end
        rdy_i[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (vld_o[0] !== 1'b1 || dat_o[0] !== 8'hA1 + 8'(k)) begin
                fails++; $display("FAIL drain_order beat%0d got vld=%b data=%h exp %h", k, vld_o[0], dat_o[0], 8'hA1 + 8'(k));
            end
            cycle();
        end
        rdy_i[0] = 1'b0; vld_i[0] = 1'b1; dat_i[0] = 8'hB0;
        cycle();
        vld_i[0] = 1'b0;
        #1;
        tests++;
        if (vld_o[0] !== 1'b1 || dat_o[0] !== 8'hB0 || c0 !== 2'd1) begin
            fails++; $display("FAIL wrap_push got vld=%b data=%h cnt=%0d exp 1 b0 1", vld_o[0], dat_o[0], c0);
        end
        flush_all();
    endtask

    task automatic test_back_to_back();
        vld_i[1] = 1'b1; dat_i[1] = 8'h10; rdy_i[1] = 1'b0;
        cycle();
        rdy_i[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            dat_i[1] = 8'h11 + 8'(k);
            #1;
            tests++;
            if (c1 !== 3'd1 || vld_o[1] !== 1'b1 || dat_o[1] !== 8'h10 + 8'(k)) begin
                fails++; $display("FAIL stream beat%0d got cnt=%0d vld=%b data=%h exp 1 1 %h", k, c1, vld_o[1], dat_o[1], 8'h10 + 8'(k));
            end
            cycle();
        end
        vld_i[1] = 1'b0;
        cycle();
        idle_all();
    endtask

    task automatic test_fall_through();
        vld_i[2] = 1'b1; dat_i[2] = 8'h55; rdy_i[2] = 1'b1;
        #1;
        tests++;
        if (vld_o[2] !== 1'b1 || dat_o[2] !== 8'h55 || c2 !== 3'd0) begin
            fails++; $display("FAIL bypass got vld=%b data=%h cnt=%0d exp 1 55 0", vld_o[2], dat_o[2], c2);
        end
        cycle();
        vld_i[2] = 1'b0;
        #1;
        tests++;
        if (c2 !== 3'd0) begin
            fails++; $display("FAIL bypass_count got %0d exp 0", c2);
        end
        vld_i[2] = 1'b1; rdy_i[2] = 1'b0;
        cycle();
        vld_i[2] = 1'b0; dat_i[2] = 8'h00;
        #1;
        tests++;
        if (c2 !== 3'd1 || vld_o[2] !== 1'b1 || dat_o[2] !== 8'h55) begin
            fails++; $display("FAIL ft_store got cnt=%0d vld=%b data=%h exp 1 1 55", c2, vld_o[2], dat_o[2]);
        end
        rdy_i[2] = 1'b1;
        cycle();
        idle_all();
    endtask

    task automatic test_flush();
        vld_i[1] = 1'b1; rdy_i[1] = 1'b0;
        dat_i[1] = 8'h21; cycle();
        dat_i[1] = 8'h22; cycle();
        fl_i[1] = 1'b1; rdy_i[1] = 1'b1; dat_i[1] = 8'hEE;
        #1;
        tests++;
        if (rdy_o[1] !== 1'b0) begin
            fails++; $display("FAIL flush_ready got %b exp 0", rdy_o[1]);
        end
        cycle();
        fl_i[1] = 1'b0; vld_i[1] = 1'b0;
        #1;
        tests++;
        if (c1 !== 3'd0 || vld_o[1] !== 1'b0) begin
            fails++; $display("FAIL flush_clear got cnt=%0d vld=%b exp 0 0", c1, vld_o[1]);
        end
        cycle();
        idle_all();
    endtask

    task automatic test_depth1();
        logic [7:0] got [8];
        int   ngot = 0;
        int   n = 1;
        logic prev_rdy = 1'b0;
        rdy_i[3] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            vld_i[3] = (n <= 8);
            dat_i[3] = 8'(n);
            #1;
            if (k > 0 && k < 16) begin
                tests++;
                if (rdy_o[3] === prev_rdy) begin
                    fails++; $display("FAIL d1_alternate cycle%0d got ready %b twice", k, rdy_o[3]);
                end
            end
            prev_rdy = rdy_o[3];
            if (vld_o[3] && ngot < 8) begin
                got[ngot] = dat_o[3];
                ngot++;
            end
            if (rdy_o[3] && vld_i[3]) n++;
            cycle();
        end
        tests++;
        if (ngot != 8) begin
            fails++; $display("FAIL d1_beats got %0d exp 8", ngot);
        end
        for (int j = 0; j < ngot; j++) begin
            tests++;
            if (got[j] !== 8'(j + 1)) begin
                fails++; $display("FAIL d1_order beat%0d got %h exp %h", j, got[j], 8'(j + 1));
            end
        end
        idle_all();
    endtask

    task automatic test_reset_mid();
        vld_i[0] = 1'b1; rdy_i[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dat_i[0] = 8'hC0 + 8'(k);
            cycle();
        end
        vld_i[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (c0 !== 2'd0 || vld_o[0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
            fails++; $display("FAIL async_reset got cnt=%0d vld=%b rdy=%b exp 0 0 1", c0, vld_o[0], rdy_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vld_i[0] = 1'b1; dat_i[0] = 8'h77;
        cycle();
        vld_i[0] = 1'b0;
        #1;
        tests++;
        if (vld_o[0] !== 1'b1 || dat_o[0] !== 8'h77) begin
            fails++; $display("FAIL post_reset_push got vld=%b data=%h exp 1 77", vld_o[0], dat_o[0]);
        end
        flush_all();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) begin
                vld_i[i] = ($urandom % 10) < 7;
                rdy_i[i] = ($urandom % 10) < 6;
                fl_i[i]  = ($urandom % 20) == 0;
                dat_i[i] = 8'($urandom);
            end
            cycle();
        end
        idle_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_all();
        model_reset();
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_fill_drain();
        test_back_to_back();
        test_fall_through();
        test_flush();
        test_depth1();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
